// File: rtl/reg_file_wr_arb.sv
// Write-port sequencer for reg_file.
// After reset, or on init_req, it clears every entry to CLR_VAL. Otherwise it
// shares the single write port between two requesters in round-robin order.
module reg_file_wr_arb #(
    parameter int unsigned     BITS    = 4,
    parameter int unsigned     DEPTH   = 16,
    parameter int unsigned     ADDR    = 4,
    parameter logic [BITS-1:0] CLR_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_req,
    input  logic            req0_valid,
    input  logic [ADDR-1:0] req0_addr,
    input  logic [BITS-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [ADDR-1:0] req1_addr,
    input  logic [BITS-1:0] req1_data,
    output logic            req1_ready,
    output logic            WE,
    output logic [ADDR-1:0] WA,
    output logic [BITS-1:0] WD,
    output logic            init_busy
);

    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [ADDR-1:0] ptr;
    logic [ADDR-1:0] ptr_d;
    // rr == 0 : requester 0 holds priority; rr == 1 : requester 1 holds priority
    logic            rr;
    logic            rr_d;
    logic            we_d;
    logic [ADDR-1:0] wa_d;
    logic [BITS-1:0] wd_d;
    logic            busy_d;

    // State and registered write-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            ptr       <= '0;
            rr        <= 1'b0;
            WE        <= 1'b0;
            WA        <= '0;
            WD        <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            rr        <= rr_d;
            WE        <= we_d;
            WA        <= wa_d;
            WD        <= wd_d;
            init_busy <= busy_d;
        end
    end

    // Next state, sweep pointer, grant decision and next write-port values
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        rr_d       = rr;
        we_d       = 1'b0;
        wa_d       = WA;
        wd_d       = WD;
        busy_d     = init_busy;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state)
            ST_INIT: begin
                we_d   = 1'b1;
                wa_d   = ptr;
                wd_d   = CLR_VAL;
                ptr_d  = ptr + ADDR'(1);
                busy_d = 1'b1;
                // The cycle that issues the last entry also leaves the sweep
                if (ptr == LAST_ADDR) begin
                    state_d = ST_ARB;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_ARB: begin
                busy_d = 1'b0;
                if (init_req) begin
                    // A clear request wins over any pending write this cycle
                    state_d = ST_INIT;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    req0_ready = req0_valid && (!req1_valid || !rr);
                    req1_ready = req1_valid && (!req0_valid ||  rr);
                    if (req0_ready) begin
                        we_d = 1'b1;
                        wa_d = req0_addr;
                        wd_d = req0_data;
                        rr_d = 1'b1;
                    end else if (req1_ready) begin
                        we_d = 1'b1;
                        wa_d = req1_addr;
                        wd_d = req1_data;
                        rr_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule
